// File: rtl/frame_transfer_packer.sv
// frame_transfer_packer
//   Packs a stream of 24-bit RGB pixels into 32-bit words, four pixels to
//   three words, per macroblock. Macroblock closing (normal, early end or
//   missing end) tags the final word Last. Words go into a first-word
//   fall-through output FIFO with valid/ready handshake.
//
// Build option:
//   FRAME_PACKER_STATS_EN  when defined, ul16MacroBlockCount counts closed
//                          macroblocks (wrapping); otherwise it is tied to 0.
//
// Ports:
//   ul1Clock             single clock
//   ul1Reset             synchronous active-high reset
//   ul1InActive          input pixel valid (no backpressure)
//   ul24InRgb24Data      RGB24 pixel
//   ul1InMacroBlockEnd   last pixel of macroblock (qualified by ul1InActive)
//   ul2InMacroBlockType  0=16x16, 1=8x8, 2=4x4, 3=16x16
//   ul32OutData          packed word (0 while FIFO empty)
//   ul1OutValid          word available
//   ul1OutReady          downstream accepts word
//   ul1OutLast           word is last of its macroblock
//   ul1Overflow          sticky: word dropped on full FIFO
//   ul1SizeError         sticky: macroblock pixel count mismatch
//   ul16MacroBlockCount  closed macroblock count (stats build only)
//
// Packer phase:
//   state | meaning
//   PH_P0 | next pixel starts a word group; no word emitted
//   PH_P1 | holding 3 bytes; next pixel completes word0
//   PH_P2 | holding 2 bytes; next pixel completes word1
//   PH_P3 | holding 1 byte;  next pixel completes word2

module frame_transfer_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset,
  input  logic        ul1InActive,
  input  logic [23:0] ul24InRgb24Data,
  input  logic        ul1InMacroBlockEnd,
  input  logic [1:0]  ul2InMacroBlockType,
  output logic [31:0] ul32OutData,
  output logic        ul1OutValid,
  input  logic        ul1OutReady,
  output logic        ul1OutLast,
  output logic        ul1Overflow,
  output logic        ul1SizeError,
  output logic [15:0] ul16MacroBlockCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {PH_P0, PH_P1, PH_P2, PH_P3} phase_e;

  phase_e            phase_q, phase_d;
  logic [23:0]       res_q, res_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        type_q, type_d;
  logic              pend_vld_q, pend_vld_d;
  logic [32:0]       pend_word_q, pend_word_d;
  logic              ovf_q, ovf_d;
  logic              size_err_q, size_err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    fill_q, fill_d;
  logic [32:0]       mem_q [FIFO_DEPTH];

  logic [1:0]        cur_type;
  logic [8:0]        exp_cnt;
  logic [8:0]        px_cnt;
  logic              at_exp;
  logic              early_end;
  logic              mb_close;
  logic              word_a_vld, word_b_vld;
  logic [32:0]       word_a, word_b;
  logic              wr_req, wr_en, rd_en, fifo_full;
  logic [32:0]       wr_word;

  // Packer. Bit 32 of a word is the Last tag. An early end on phase 1 or 2
  // produces two words in one cycle: the completed word and the zero-padded
  // flush word (word_b).
  always_comb begin
    phase_d    = phase_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    size_err_d = size_err_q;
    word_a_vld = 1'b0;
    word_a     = '0;
    word_b_vld = 1'b0;
    word_b     = '0;
    early_end  = 1'b0;
    mb_close   = 1'b0;

    // first pixel of a macroblock uses the live type, later pixels the latched one
    cur_type = (cnt_q == 9'd0) ? ul2InMacroBlockType : type_q;
    case (cur_type)
      2'd1:    exp_cnt = 9'd64;
      2'd2:    exp_cnt = 9'd16;
      default: exp_cnt = 9'd256;
    endcase
    px_cnt = cnt_q + 9'd1;
    at_exp = (px_cnt == exp_cnt);

    if (ul1InActive) begin
      type_d    = cur_type;
      early_end = ul1InMacroBlockEnd && !at_exp;
      mb_close  = ul1InMacroBlockEnd || at_exp;
      if (early_end || (at_exp && !ul1InMacroBlockEnd)) begin
        size_err_d = 1'b1;
      end

      case (phase_q)
        PH_P0: begin
          res_d   = ul24InRgb24Data;
          phase_d = PH_P1;
          if (early_end) begin
            word_a_vld = 1'b1;
            word_a     = {1'b1, 8'h00, ul24InRgb24Data};
          end
        end
        PH_P1: begin
          word_a_vld = 1'b1;
          word_a     = {1'b0, ul24InRgb24Data[7:0], res_q};
          res_d      = {8'h00, ul24InRgb24Data[23:8]};
          phase_d    = PH_P2;
          if (early_end) begin
            word_b_vld = 1'b1;
            word_b     = {1'b1, 16'h0000, ul24InRgb24Data[23:8]};
          end
        end
        PH_P2: begin
          word_a_vld = 1'b1;
          word_a     = {1'b0, ul24InRgb24Data[15:0], res_q[15:0]};
          res_d      = {16'h0000, ul24InRgb24Data[23:16]};
          phase_d    = PH_P3;
          if (early_end) begin
            word_b_vld = 1'b1;
            word_b     = {1'b1, 24'h000000, ul24InRgb24Data[23:16]};
          end
        end
        PH_P3: begin
          word_a_vld = 1'b1;
          word_a     = {mb_close, ul24InRgb24Data, res_q[7:0]};
          res_d      = '0;
          phase_d    = PH_P0;
        end
      endcase

      if (mb_close) begin
        phase_d = PH_P0;
        cnt_d   = 9'd0;
        res_d   = '0;
      end else begin
        cnt_d = px_cnt;
      end
    end
  end

  // One FIFO write per cycle. A pending word exists only right after a
  // macroblock closed, so the current pixel is a phase-0 pixel producing at
  // most one word and one holding slot is always enough.
  always_comb begin
    wr_req      = 1'b0;
    wr_word     = '0;
    pend_vld_d  = 1'b0;
    pend_word_d = pend_word_q;
    if (pend_vld_q) begin
      wr_req  = 1'b1;
      wr_word = pend_word_q;
      if (word_a_vld) begin
        pend_vld_d  = 1'b1;
        pend_word_d = word_a;
      end
    end else if (word_a_vld) begin
      wr_req  = 1'b1;
      wr_word = word_a;
      if (word_b_vld) begin
        pend_vld_d  = 1'b1;
        pend_word_d = word_b;
      end
    end
  end

  // Output FIFO; a read frees a slot in the same cycle so a write into a
  // full FIFO that is being read is not dropped.
  always_comb begin
    rd_en     = (fill_q != '0) && ul1OutReady;
    fifo_full = (fill_q == FILL_FULL);
    wr_en     = wr_req && (!fifo_full || rd_en);
    ovf_d     = ovf_q | (wr_req & ~wr_en);
    wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
      2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      phase_q     <= PH_P0;
      res_q       <= '0;
      cnt_q       <= '0;
      type_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= '0;
      ovf_q       <= 1'b0;
      size_err_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      ovf_q       <= ovf_d;
      size_err_q  <= size_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // storage needs no reset: contents are only visible while fill_q != 0
  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset && wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign ul1OutValid  = (fill_q != '0);
  assign ul32OutData  = ul1OutValid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign ul1OutLast   = ul1OutValid & mem_q[rd_ptr_q][32];
  assign ul1Overflow  = ovf_q;
  assign ul1SizeError = size_err_q;

`ifdef FRAME_PACKER_STATS_EN
  logic [15:0] mb_cnt_q, mb_cnt_d;

  always_comb begin
    mb_cnt_d = mb_close ? mb_cnt_q + 16'd1 : mb_cnt_q;
  end

  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      mb_cnt_q <= '0;
    end else begin
      mb_cnt_q <= mb_cnt_d;
    end
  end

  assign ul16MacroBlockCount = mb_cnt_q;
`else
  assign ul16MacroBlockCount = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_transfer_packer.sv
module tb_frame_transfer_packer;

  localparam int DEPTH = 16;

  logic        ul1Clock = 1'b0;
  logic        ul1Reset = 1'b1;
  logic        ul1InActive = 1'b0;
  logic [23:0] ul24InRgb24Data = '0;
  logic        ul1InMacroBlockEnd = 1'b0;
  logic [1:0]  ul2InMacroBlockType = '0;
  logic [31:0] ul32OutData;
  logic        ul1OutValid;
  logic        ul1OutReady = 1'b0;
  logic        ul1OutLast;
  logic        ul1Overflow;
  logic        ul1SizeError;
  logic [15:0] ul16MacroBlockCount;

  frame_transfer_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .ul1Clock            (ul1Clock),
    .ul1Reset            (ul1Reset),
    .ul1InActive         (ul1InActive),
    .ul24InRgb24Data     (ul24InRgb24Data),
    .ul1InMacroBlockEnd  (ul1InMacroBlockEnd),
    .ul2InMacroBlockType (ul2InMacroBlockType),
    .ul32OutData         (ul32OutData),
    .ul1OutValid         (ul1OutValid),
    .ul1OutReady         (ul1OutReady),
    .ul1OutLast          (ul1OutLast),
    .ul1Overflow         (ul1Overflow),
    .ul1SizeError        (ul1SizeError),
    .ul16MacroBlockCount (ul16MacroBlockCount)
  );

  always #5 ul1Clock = ~ul1Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: byte stream per macroblock ----------
  logic [32:0] exp_q[$];
  logic [7:0]  mb_bytes[$];
  int          m_cnt = 0;
  logic [1:0]  m_type = '0;
  bit          m_err = 0;
  int          m_closes = 0;
  bit          use_model = 1;

  function automatic int exp_px(input logic [1:0] t);
    case (t)
      2'd1:    return 64;
      2'd2:    return 16;
      default: return 256;
    endcase
  endfunction

  function automatic logic [15:0] stat_exp(input int closes);
`ifdef FRAME_PACKER_STATS_EN
    return 16'(closes);
`else
    return 16'(closes & 0);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mb_bytes.delete();
    m_cnt = 0;
    m_err = 0;
    m_closes = 0;
  endtask

  task automatic model_pixel(input logic [23:0] px, input bit endf, input logic [1:0] typ);
    logic [32:0] w;
    int n;
    if (m_cnt == 0) m_type = typ;
    m_cnt++;
    mb_bytes.push_back(px[7:0]);
    mb_bytes.push_back(px[15:8]);
    mb_bytes.push_back(px[23:16]);
    while (mb_bytes.size() >= 4) begin
      w = '0;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = mb_bytes.pop_front();
      exp_q.push_back(w);
    end
    n = exp_px(m_type);
    if (endf || m_cnt == n) begin
      if (m_cnt != n || !endf) m_err = 1;
      if (mb_bytes.size() != 0) begin
        w = '0;
        w[32] = 1'b1;
        for (int b = 0; b < 4; b++) if (mb_bytes.size() != 0) w[8*b +: 8] = mb_bytes.pop_front();
        exp_q.push_back(w);
      end else begin
        w = exp_q.pop_back();
        w[32] = 1'b1;
        exp_q.push_back(w);
      end
      m_cnt = 0;
      m_closes++;
    end
  endtask

  // ---------------- observation of accepted words -------------------------
  int          obs_n = 0;
  int          obs_nlast = 0;
  logic [31:0] obs_first = '0;
  logic [31:0] obs_final = '0;

  task automatic clear_obs();
    obs_n = 0;
    obs_nlast = 0;
    obs_first = '0;
    obs_final = '0;
  endtask

  // One cycle: at the falling edge observe the word that the coming rising
  // edge will accept, then drive the inputs for that edge.
  task automatic step(input bit rst, input bit act, input logic [23:0] px,
                      input bit endf, input logic [1:0] typ, input bit rdy);
    @(negedge ul1Clock);
    if (!rst && ul1OutValid && rdy) begin
      obs_n++;
      if (obs_n == 1) obs_first = ul32OutData;
      obs_final = ul32OutData;
      if (ul1OutLast) obs_nlast++;
      if (use_model) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stream_word: got 0x%0h last %0b, expected no word", ul32OutData, ul1OutLast);
        end else begin
          check("stream_word", {31'h0, ul1OutLast, ul32OutData}, {31'h0, exp_q.pop_front()});
        end
      end
    end
    ul1Reset            = rst;
    ul1InActive         = act;
    ul24InRgb24Data     = px;
    ul1InMacroBlockEnd  = endf;
    ul2InMacroBlockType = typ;
    ul1OutReady         = rdy;
    if (rst) model_reset();
    else if (act) model_pixel(px, endf, typ);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 24'($urandom), 1'($urandom), 2'($urandom), rdy);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    clear_obs();
  endtask

  function automatic logic [23:0] pix(input bit pat, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (pat) return {b + 8'hC0, b + 8'h80, b};
    return 24'(i);
  endfunction

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic [1:0]  typ;
    logic [1:0]  alt;      // type driven on pixels 2..n (must be ignored)
    bit          pat;
    int          npx;
    int          endpos;   // 0 = end never asserted
    int          nwords;
    logic [31:0] first_w;
    logic [31:0] final_w;
    int          nlast;
    bit          err;
    int          closes;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd2, 2'd2, 1'b0,  16,  16,  12, 32'h02000001, 32'h00001000, 1, 1'b0, 1};
    vecs[1] = '{2'd1, 2'd1, 1'b1,   6,   6,   5, 32'h02C18101, 32'h0000C686, 1, 1'b1, 1};
    vecs[2] = '{2'd2, 2'd2, 1'b0,  20,   0,  15, 32'h02000001, 32'h00001400, 1, 1'b1, 1};
    vecs[3] = '{2'd2, 2'd2, 1'b1,   1,   1,   1, 32'h00C18101, 32'h00C18101, 1, 1'b1, 1};
    vecs[4] = '{2'd2, 2'd2, 1'b1,   3,   3,   3, 32'h02C18101, 32'h000000C3, 1, 1'b1, 1};
    vecs[5] = '{2'd3, 2'd3, 1'b0,   8,   8,   6, 32'h02000001, 32'h00000800, 1, 1'b1, 1};
    vecs[6] = '{2'd0, 2'd0, 1'b0, 256, 256, 192, 32'h02000001, 32'h00010000, 1, 1'b0, 1};
    vecs[7] = '{2'd1, 2'd1, 1'b1,  64,  64,  48, 32'h02C18101, 32'h00C040FF, 1, 1'b0, 1};
    vecs[8] = '{2'd2, 2'd0, 1'b0,  16,  16,  12, 32'h02000001, 32'h00001000, 1, 1'b0, 1};

    // reset state
    do_reset();
    idle(0);
    check("rst_valid", ul1OutValid, 0);
    check("rst_data", ul32OutData, 0);
    check("rst_last", ul1OutLast, 0);
    check("rst_ovf", ul1Overflow, 0);
    check("rst_size_err", ul1SizeError, 0);
    check("rst_mb_count", ul16MacroBlockCount, 0);

    foreach (vecs[v]) begin
      do_reset();
      for (int i = 1; i <= vecs[v].npx; i++)
        step(0, 1, pix(vecs[v].pat, i), i == vecs[v].endpos,
             (i == 1) ? vecs[v].typ : vecs[v].alt, 1);
      for (int k = 0; k < 12; k++) idle(1);
      check($sformatf("v%0d_words", v), obs_n, vecs[v].nwords);
      check($sformatf("v%0d_first", v), obs_first, vecs[v].first_w);
      check($sformatf("v%0d_final", v), obs_final, vecs[v].final_w);
      check($sformatf("v%0d_nlast", v), obs_nlast, vecs[v].nlast);
      check($sformatf("v%0d_size_err", v), ul1SizeError, vecs[v].err);
      check($sformatf("v%0d_ovf", v), ul1Overflow, 0);
      check($sformatf("v%0d_mb_count", v), ul16MacroBlockCount, stat_exp(vecs[v].closes));
      check($sformatf("v%0d_model_empty", v), exp_q.size(), 0);
    end

    // overflow: two 4x4 macroblocks into a 16-deep FIFO with ready low
    use_model = 0;
    do_reset();
    for (int g = 0; g < 32; g++) step(0, 1, pix(0, (g % 16) + 1), (g % 16) == 15, 2'd2, 0);
    idle(0);
    check("ovf_flag", ul1Overflow, 1);
    check("ovf_hold_data", ul32OutData, 32'h02000001);
    for (int k = 0; k < 3; k++) idle(0);
    check("ovf_hold_data2", ul32OutData, 32'h02000001);
    check("ovf_hold_valid", ul1OutValid, 1);
    clear_obs();
    for (int k = 0; k < 40; k++) idle(1);
    check("ovf_words", obs_n, 16);
    check("ovf_nlast", obs_nlast, 1);
    check("ovf_final", obs_final, 32'h06000005);
    check("ovf_size_err", ul1SizeError, 0);
    check("ovf_mb_count", ul16MacroBlockCount, stat_exp(2));
    use_model = 1;

    // full FIFO read and write in the same cycle
    do_reset();
    for (int g = 0; g < 32; g++) step(0, 1, pix(0, (g % 16) + 1), (g % 16) == 15, 2'd2, g >= 22);
    for (int k = 0; k < 40; k++) idle(1);
    check("full_rw_ovf", ul1Overflow, 0);
    check("full_rw_words", obs_n, 24);
    check("full_rw_model_empty", exp_q.size(), 0);

    // reset in the middle of a 16x16 macroblock
    do_reset();
    for (int i = 1; i <= 7; i++) step(0, 1, pix(1, i), 0, 2'd0, 0);
    step(1, 1, 24'h123456, 1, 2'd2, 0);
    idle(0);
    check("midrst_valid", ul1OutValid, 0);
    check("midrst_data", ul32OutData, 0);
    clear_obs();
    for (int i = 1; i <= 16; i++) step(0, 1, pix(0, i), i == 16, 2'd2, 1);
    for (int k = 0; k < 12; k++) idle(1);
    check("midrst_words", obs_n, 12);
    check("midrst_first", obs_first, 32'h02000001);
    check("midrst_nlast", obs_nlast, 1);
    check("midrst_size_err", ul1SizeError, 0);
    check("midrst_ovf", ul1Overflow, 0);

    // randomized macroblocks against the model
    do_reset();
    for (int blk = 0; blk < 40; blk++) begin
      logic [1:0] typ;
      int n, endpos, r, last_px;
      typ = 2'($urandom_range(0, 3));
      n = exp_px(typ);
      r = $urandom_range(0, 3);
      if (r == 0) endpos = $urandom_range(1, n - 1);
      else if (r == 1) endpos = n + 1;
      else endpos = n;
      last_px = (endpos > n) ? n : endpos;
      for (int i = 1; i <= last_px; i++) begin
        while ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3) != 0);
        step(0, 1, 24'($urandom), i == endpos, (i == 1) ? typ : 2'($urandom),
             $urandom_range(0, 3) != 0);
      end
    end
    for (int k = 0; k < 60; k++) idle(1);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_size_err", ul1SizeError, m_err);
    check("rand_ovf", ul1Overflow, 0);
    check("rand_mb_count", ul16MacroBlockCount, stat_exp(m_closes));
    check("rand_valid_idle", ul1OutValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
